// File: rtl/dac_i2s_rx.sv
// I2S receiver: samples an external BCLK/LRCLK/DIN stream on CLK and presents L/R sample pairs.
// Define DAC_I2S_RX_PHILIPS_EN for Philips I2S framing (MSB one BCLK after the LRCLK edge).
`timescale 1ns/1ps
module dac_i2s_rx #(
  parameter int bit_width = 16,
  parameter int out_width = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  input  logic                 BCLK,
  input  logic                 LRCLK,
  input  logic                 DIN,
  output logic [out_width-1:0] OUT_L,
  output logic [out_width-1:0] OUT_R,
  output logic                 VALID,
  output logic                 LOCKED
);

  localparam int CW = $clog2(bit_width + 1);
  localparam logic [CW-1:0]        BW_C  = CW'(bit_width);
  localparam logic [bit_width-1:0] MSB_C = {1'b1, {(bit_width-1){1'b0}}};

  // Left-aligned resize: keep the top bits, or pad with zeros below.
  function automatic logic [out_width-1:0] fmt(input logic [bit_width-1:0] w);
    logic [bit_width+out_width-1:0] t;
    t = {w, {out_width{1'b0}}};
    return t[bit_width+out_width-1 -: out_width];
  endfunction

  logic [2:0]           bclk_sync_q, bclk_sync_d;
  logic [1:0]           lrclk_sync_q, lrclk_sync_d;
  logic [1:0]           din_sync_q, din_sync_d;
  logic                 primed_q, primed_d;
  logic                 lr_prev_q, lr_prev_d;
  logic                 locked_q, locked_d;
  logic [bit_width-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [bit_width-1:0] hold_l_q, hold_l_d;
  logic                 hold_l_vld_q, hold_l_vld_d;
  logic [out_width-1:0] out_l_q, out_l_d;
  logic [out_width-1:0] out_r_q, out_r_d;
  logic                 valid_q, valid_d;

  logic strobe, lr_s, d_s, lr_eff;

  assign strobe = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lr_s   = lrclk_sync_q[1];
  assign d_s    = din_sync_q[1];

`ifdef DAC_I2S_RX_PHILIPS_EN
  logic lr_dly_q, lr_dly_d;
  assign lr_eff = lr_dly_q;

  always_comb begin
    lr_dly_d = lr_dly_q;
    if (strobe) lr_dly_d = lr_s;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) lr_dly_q <= 1'b0;
    else          lr_dly_q <= lr_dly_d;
  end
`else
  assign lr_eff = lr_s;
`endif

  always_comb begin
    bclk_sync_d  = {bclk_sync_q[1:0], BCLK};
    lrclk_sync_d = {lrclk_sync_q[0], LRCLK};
    din_sync_d   = {din_sync_q[0], DIN};
    primed_d     = primed_q;
    lr_prev_d    = lr_prev_q;
    locked_d     = locked_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    hold_l_d     = hold_l_q;
    hold_l_vld_d = hold_l_vld_q;
    out_l_d      = out_l_q;
    out_r_d      = out_r_q;
    valid_d      = 1'b0;
    if (strobe) begin
      // The first strobe only learns the current LRCLK level, so a static
      // LRCLK at reset release is never mistaken for a transition.
      if (!primed_q) begin
        primed_d  = 1'b1;
        lr_prev_d = lr_s;
      end else if (lr_eff != lr_prev_q) begin
        lr_prev_d = lr_eff;
        locked_d  = 1'b1;
        shift_d   = d_s ? MSB_C : '0;
        cnt_d     = CW'(1);
        if (locked_q) begin
          if (!lr_prev_q) begin
            hold_l_d     = shift_q;
            hold_l_vld_d = 1'b1;
          end else if (hold_l_vld_q) begin
            out_l_d = fmt(hold_l_q);
            out_r_d = fmt(shift_q);
            valid_d = 1'b1;
          end
        end
      end else if (cnt_q < BW_C) begin
        if (d_s) shift_d = shift_q | (MSB_C >> cnt_q);
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      din_sync_q   <= '0;
      primed_q     <= 1'b0;
      lr_prev_q    <= 1'b0;
      locked_q     <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      hold_l_q     <= '0;
      hold_l_vld_q <= 1'b0;
      out_l_q      <= '0;
      out_r_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrclk_sync_q <= lrclk_sync_d;
      din_sync_q   <= din_sync_d;
      primed_q     <= primed_d;
      lr_prev_q    <= lr_prev_d;
      locked_q     <= locked_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      hold_l_q     <= hold_l_d;
      hold_l_vld_q <= hold_l_vld_d;
      out_l_q      <= out_l_d;
      out_r_q      <= out_r_d;
      valid_q      <= valid_d;
    end
  end

  assign OUT_L  = out_l_q;
  assign OUT_R  = out_r_q;
  assign VALID  = valid_q;
  assign LOCKED = locked_q;

endmodule
